multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the shared multi-cycle mult/div unit for the 5-stage pipeline.
//  Issues the unit from DX, holds the in-flight IR (the PW slot) and stalls FD on hazards against it.
//  Arbitrates the single regfile write port with MW writeback; MW has priority.
//  A losing mult/div result is buffered until the port is free.
// PARAMETERS
//  MULT_ALUOP  5'd6   ALU func (IR[6:2]) selecting mult when opcode==0
//  DIV_ALUOP   5'd7   ALU func selecting div when opcode==0
//  EXC_REG     5'd30  rstatus register written on exception
//  MULT_EXC    32'd4  rstatus value on mult overflow
//  DIV_EXC     32'd5  rstatus value on div-by-zero
//  TIMEOUT     40     max cycles RUN may last before md_timeout
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   synchronous, active-high
//  fd_ir         in   32  instruction in FD (hazard check)
//  dx_ir         in   32  instruction in DX (issue check)
//  mw_we         in   1   MW stage writes regfile this cycle
//  md_ready      in   1   unit result valid (1-cycle pulse)
//  md_exception  in   1   unit exception, qualified by md_ready
//  md_result     in   32  unit result, qualified by md_ready
//  ctrl_mult     out  1   1-cycle start pulse, mult
//  ctrl_div      out  1   1-cycle start pulse, div
//  pw_ir         out  32  latched in-flight IR (0 when idle)
//  busy          out  1   state != IDLE
//  stall         out  1   freeze FD/PC (comb.)
//  md_we         out  1   mult/div regfile write strobe
//  md_wd         out  5   mult/div write register
//  md_data       out  32  mult/div write data
//  md_timeout    out  1   sticky; set on RUN timeout
// BEHAVIOUR
//  - Decode:
//    - is_md(ir) = ir[31:27]==0 && ir[6:2] in {MULT_ALUOP, DIV_ALUOP}.
//    - rd=[26:22], rs=[21:17], rt=[16:12].
//  - FD read set by opcode:
//    - 0: {rs,rt}; 2,4,6: {rd,rs}; 7: {rs}; 8: {rs,rd}; 22: {30}; else {}.
//    - Write set: rd for opcodes 0,5,8; 31 for 3; 30 for 21.
//  - States IDLE, RUN, HOLD. Reset: IDLE, all outputs 0, counter 0, md_timeout 0.
//  - IDLE: if is_md(dx_ir):
//    - pulse ctrl_mult/ctrl_div for exactly 1 cycle;
//    - pw_ir<=dx_ir, cnt<=0, go RUN.
//  - RUN: cnt increments each cycle, saturating.
//    - md_ready & !mw_we: drive write (md_we/md_wd/md_data) this same cycle (comb.), next IDLE.
//    - md_ready & mw_we: latch wd/data into hold reg, next HOLD.
//    - cnt==TIMEOUT-1 w/o md_ready: set md_timeout, next IDLE, no write.
//  - HOLD: md_ready ignored. When mw_we==0, drive buffered write, next IDLE.
//  - Write target/data:
//    - md_exception=1: wd=EXC_REG, data=MULT_EXC or DIV_EXC per pw_ir func.
//    - else: wd=pw_ir rd, data=md_result.
//    - wd==0 -> md_we held 0; the op still completes.
//  - stall=1 when state!=IDLE and any of:
//    - FD read or write set contains pw_ir rd, or EXC_REG (rd != 0);
//    - is_md(fd_ir).
//    - Stall holds through the write cycle; it drops the cycle after return to IDLE.
//  - A new is_md(dx_ir) is never seen while busy (guaranteed by stall). If it is seen, ignore it; no second pulse.
//  - md_ready in IDLE: ignored.
//  - md_we never asserts in a cycle with mw_we=1.
//  - pw_ir clears to 0 on entry to IDLE.
//  - Reset mid-RUN/HOLD: IDLE next cycle, buffered result dropped, no write.
// TESTING
//  - mult $3,$1,$2 in DX:
//    - ctrl_mult=1 one cycle, busy=1;
//    - md_ready@+17 w/ mw_we=0, result=42 -> md_we=1, wd=3, data=42 that cycle; busy=0 next.
//  - Port conflict: md_ready with mw_we=1 for 3 cycles, data=7, rd=9.
//    - md_we=0 for those 3 cycles; md_we=1, wd=9, data=7 on the 1st mw_we=0 cycle.
//  - div, md_exception=1 -> wd=30, data=5; mult, md_exception=1 -> wd=30, data=4.
//  - Hazards while busy on rd=3:
//    - fd_ir add $5,$3,$1 -> stall=1; add $5,$4,$1 -> stall=0.
//    - fd_ir = another mult -> stall=1; bex -> stall=1 only on exception path (reads 30).
//  - Timeout: no md_ready for 40 cycles -> md_timeout=1 and stays set; busy=0; md_we never 1.
//  - Reset during HOLD -> next cycle busy=0, pw_ir=0, md_we=0; rd=0 mult -> completes, md_we=0.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle mult/div unit: issue from DX, track the in-flight IR, arbitrate the regfile port.
// Latency: start pulse 1 cycle after issue; result written the cycle md_ready arrives unless MW owns the port.
// Backpressure: MW writeback wins the regfile port; a losing result waits in a hold register; FD is stalled on hazards.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   fd_ir, dx_ir          instructions in FD (hazard check) and DX (issue check)
//   mw_we                 MW stage owns the regfile write port this cycle
//   md_ready/_exception   unit result strobe and exception flag (qualified by md_ready)
//   md_result             unit result data
//   ctrl_mult/ctrl_div    one-cycle start pulses to the unit
//   pw_ir                 in-flight instruction (0 when idle)
//   busy, stall           sequencer occupied; freeze FD/PC
//   md_we/md_wd/md_data   mult/div regfile write
//   md_timeout            sticky: the unit never answered
module multdiv_sequencer #(
    parameter logic [4:0]  MULT_ALUOP = 5'd6,
    parameter logic [4:0]  DIV_ALUOP  = 5'd7,
    parameter logic [4:0]  EXC_REG    = 5'd30,
    parameter logic [31:0] MULT_EXC   = 32'd4,
    parameter logic [31:0] DIV_EXC    = 32'd5,
    parameter int          TIMEOUT    = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        mw_we,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] pw_ir,
    output logic        busy,
    output logic        stall,
    output logic        md_we,
    output logic [4:0]  md_wd,
    output logic [31:0] md_data,
    output logic        md_timeout
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    function automatic logic is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && ((ir[6:2] == MULT_ALUOP) || (ir[6:2] == DIV_ALUOP));
    endfunction

    // True when register r (nonzero) is in the read or write set of ir.
    function automatic logic touches(input logic [31:0] ir, input logic [4:0] r);
        logic [4:0] op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       hit;
        op  = ir[31:27];
        rd  = ir[26:22];
        rs  = ir[21:17];
        rt  = ir[16:12];
        hit = 1'b0;
        case (op)
            5'd0:                hit = (r == rs) || (r == rt) || (r == rd);
            5'd2, 5'd4, 5'd6:    hit = (r == rd) || (r == rs);
            5'd3:                hit = (r == 5'd31);
            5'd5:                hit = (r == rd);
            5'd7:                hit = (r == rs);
            5'd8:                hit = (r == rs) || (r == rd);
            5'd21, 5'd22:        hit = (r == 5'd30);
            default:             hit = 1'b0;
        endcase
        return hit && (r != 5'd0);
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [4:0]    hold_wd;
    logic [31:0]   hold_data;

    logic          issue;
    logic          wr_slot;
    logic          latch_hold;
    logic          tmo_hit;
    logic          exc_pend;
    logic [4:0]    res_wd;
    logic [31:0]   res_data;
    logic [4:0]    wr_wd;
    logic [31:0]   wr_data;

    logic          unused_fd_bits;
    assign unused_fd_bits = ^{fd_ir[11:7], fd_ir[1:0]};

    // Where the live unit result would go this cycle.
    assign res_wd   = md_exception ? EXC_REG : pw_ir[26:22];
    assign res_data = md_exception ? ((pw_ir[6:2] == DIV_ALUOP) ? DIV_EXC : MULT_EXC)
                                   : md_result;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        wr_slot    = 1'b0;
        latch_hold = 1'b0;
        tmo_hit    = 1'b0;
        wr_wd      = res_wd;
        wr_data    = res_data;
        exc_pend   = 1'b0;
        case (state)
            IDLE: begin
                if (is_md(dx_ir)) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                exc_pend = md_ready && md_exception;
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (md_ready) begin
                    if (mw_we) begin
                        latch_hold = 1'b1;
                        state_nxt  = HOLD;
                    end else begin
                        wr_slot   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                wr_wd    = hold_wd;
                wr_data  = hold_data;
                exc_pend = (hold_wd == EXC_REG);
                if (!mw_we) begin
                    wr_slot   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A reset cycle drops any pending write; r0 writes are suppressed but still retire the op.
        md_we   = wr_slot && !reset && (wr_wd != 5'd0);
        md_wd   = md_we ? wr_wd : 5'd0;
        md_data = md_we ? wr_data : 32'd0;

        // EXC_REG only counts as a hazard once the exception outcome is actually known.
        stall = busy && (is_md(fd_ir)
                         || touches(fd_ir, pw_ir[26:22])
                         || (exc_pend && touches(fd_ir, EXC_REG)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pw_ir      <= 32'd0;
            hold_wd    <= 5'd0;
            hold_data  <= 32'd0;
            ctrl_mult  <= 1'b0;
            ctrl_div   <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctrl_mult <= issue && (dx_ir[6:2] == MULT_ALUOP);
            ctrl_div  <= issue && (dx_ir[6:2] == DIV_ALUOP);
            if (issue) begin
                pw_ir <= dx_ir;
                cnt   <= '0;
            end else begin
                if (state_nxt == IDLE) begin
                    pw_ir <= 32'd0;
                end
                if ((state == RUN) && (cnt != '1)) begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (latch_hold) begin
                hold_wd   <= res_wd;
                hold_data <= res_data;
            end
            if (tmo_hit) begin
                md_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    localparam int TMO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        mw_we;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] pw_ir;
    logic        busy;
    logic        stall;
    logic        md_we;
    logic [4:0]  md_wd;
    logic [31:0] md_data;
    logic        md_timeout;

    always #5 clock = ~clock;

    multdiv_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .mw_we        (mw_we),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .pw_ir        (pw_ir),
        .busy         (busy),
        .stall        (stall),
        .md_we        (md_we),
        .md_wd        (md_wd),
        .md_data      (md_data),
        .md_timeout   (md_timeout)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Transaction-level reference: one outstanding op, optionally parked waiting for the port.
    bit          m_busy = 0;
    bit          m_held = 0;
    bit          m_pm   = 0;
    bit          m_pd   = 0;
    bit          m_tmo  = 0;
    logic [31:0] m_pw   = 0;
    logic [4:0]  m_hwd  = 0;
    logic [31:0] m_hdat = 0;
    int          m_age  = 0;

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int fn);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(fn), 2'b00};
    endfunction

    function automatic bit m_is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    function automatic bit m_touches(input logic [31:0] ir, input logic [4:0] r);
        logic [4:0] regs[$];
        int op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        op = int'(ir[31:27]);
        rd = ir[26:22];
        rs = ir[21:17];
        rt = ir[16:12];
        case (op)
            0:       begin regs.push_back(rs); regs.push_back(rt); regs.push_back(rd); end
            2, 4, 6: begin regs.push_back(rd); regs.push_back(rs); end
            3:       regs.push_back(5'd31);
            5:       regs.push_back(rd);
            7:       regs.push_back(rs);
            8:       begin regs.push_back(rs); regs.push_back(rd); end
            21, 22:  regs.push_back(5'd30);
            default: ;
        endcase
        if (r == 5'd0) return 1'b0;
        foreach (regs[i]) if (regs[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare against the reference, then advance it as the coming edge will.
    always @(negedge clock) begin : cmp
        bit          wr;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic [4:0]  ow;
        logic [31:0] od;
        bit          exc_pend;
        bit          e_we;
        bit          e_stall;

        ow = md_exception ? 5'd30 : m_pw[26:22];
        od = md_exception ? ((m_pw[6:2] == 5'd7) ? 32'd5 : 32'd4) : md_result;

        wr = 0; wd = 0; wdat = 0;
        if (m_busy && !reset) begin
            if (m_held) begin
                if (!mw_we) begin wr = 1; wd = m_hwd; wdat = m_hdat; end
            end else if (md_ready && !mw_we) begin
                wr = 1; wd = ow; wdat = od;
            end
        end
        e_we     = wr && (wd != 0);
        exc_pend = m_held ? (m_hwd == 5'd30) : (md_ready && md_exception);
        e_stall  = m_busy && (m_is_md(fd_ir) || m_touches(fd_ir, m_pw[26:22])
                              || (exc_pend && m_touches(fd_ir, 5'd30)));

        if (chk_en) begin
            check("busy",       busy,       32'(m_busy));
            check("pw_ir",      pw_ir,      m_pw);
            check("ctrl_mult",  ctrl_mult,  32'(m_pm));
            check("ctrl_div",   ctrl_div,   32'(m_pd));
            check("md_timeout", md_timeout, 32'(m_tmo));
            check("md_we",      md_we,      32'(e_we));
            check("md_wd",      md_wd,      e_we ? 32'(wd) : 32'd0);
            check("md_data",    md_data,    e_we ? wdat : 32'd0);
            check("stall",      stall,      32'(e_stall));
        end

        if (reset) begin
            m_busy = 0; m_held = 0; m_pm = 0; m_pd = 0; m_tmo = 0; m_pw = 0; m_age = 0;
        end else begin
            m_pm = 0; m_pd = 0;
            if (!m_busy) begin
                if (m_is_md(dx_ir)) begin
                    m_busy = 1; m_pw = dx_ir; m_age = 0;
                    m_pm = (dx_ir[6:2] == 5'd6);
                    m_pd = (dx_ir[6:2] == 5'd7);
                end
            end else if (m_held) begin
                if (!mw_we) begin m_busy = 0; m_held = 0; m_pw = 0; end
            end else if (md_ready) begin
                if (mw_we) begin m_held = 1; m_hwd = ow; m_hdat = od; end
                else begin m_busy = 0; m_pw = 0; end
            end else if (m_age == TMO - 1) begin
                m_tmo = 1; m_busy = 0; m_pw = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] rreg();
        int v;
        v = $urandom_range(0, 7);
        return (v < 6) ? 5'(v) : ((v == 6) ? 5'd30 : 5'd31);
    endfunction

    function automatic logic [31:0] rand_ir();
        int ops[12] = '{0, 2, 3, 4, 5, 6, 7, 8, 21, 22, 1, 9};
        int fns[4]  = '{0, 6, 7, 1};
        return enc(ops[$urandom_range(0, 11)], rreg(), rreg(), rreg(), fns[$urandom_range(0, 3)]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nop;
        logic [31:0] bex;
        logic [31:0] mul3;
        nop  = enc(0, 0, 0, 0, 0);
        bex  = enc(22, 0, 0, 0, 0);
        mul3 = enc(0, 3, 1, 2, 6);

        reset = 1; fd_ir = nop; dx_ir = nop; mw_we = 0;
        md_ready = 0; md_exception = 0; md_result = 0;
        step();
        chk_en = 1;
        @(negedge clock);
        check("rst busy", busy, 0);
        check("rst pw_ir", pw_ir, 0);
        check("rst timeout", md_timeout, 0);
        check("rst md_we", md_we, 0);
        step();

        // mult $3,$1,$2: pulse, hazards, result on cycle +17.
        reset = 0; dx_ir = mul3;
        step(); dx_ir = nop;
        @(negedge clock);
        check("mult pulse", ctrl_mult, 1);
        check("mult no div", ctrl_div, 0);
        check("mult busy", busy, 1);
        check("mult pw_ir", pw_ir, mul3);
        step(); fd_ir = enc(0, 5, 3, 1, 0);
        @(negedge clock);
        check("pulse once", ctrl_mult, 0);
        check("haz rs=rd", stall, 1);
        step(); fd_ir = enc(0, 5, 4, 1, 0);
        @(negedge clock);
        check("no haz", stall, 0);
        step(); fd_ir = enc(0, 7, 1, 2, 6);
        @(negedge clock);
        check("haz md in fd", stall, 1);
        step(); fd_ir = bex;
        @(negedge clock);
        check("bex no exc", stall, 0);
        repeat (12) step();
        fd_ir = nop; md_ready = 1; md_result = 42;
        @(negedge clock);
        check("mult we", md_we, 1);
        check("mult wd", md_wd, 3);
        check("mult data", md_data, 42);
        step(); md_ready = 0; md_result = 0;
        @(negedge clock);
        check("mult done busy", busy, 0);
        check("mult done pw", pw_ir, 0);

        // Port conflict for three cycles.
        step(); dx_ir = enc(0, 9, 1, 2, 6);
        step(); dx_ir = nop;
        repeat (3) step();
        md_ready = 1; md_result = 7; mw_we = 1;
        @(negedge clock);
        check("conf c0 we", md_we, 0);
        step(); md_ready = 0; md_result = 32'hdead;
        @(negedge clock);
        check("conf c1 we", md_we, 0);
        step();
        @(negedge clock);
        check("conf c2 we", md_we, 0);
        step(); mw_we = 0;
        @(negedge clock);
        check("conf we", md_we, 1);
        check("conf wd", md_wd, 9);
        check("conf data", md_data, 7);
        step();
        @(negedge clock);
        check("conf done", busy, 0);

        // Div exception, with bex hazard on the exception path.
        step(); dx_ir = enc(0, 4, 1, 2, 7);
        step(); dx_ir = nop;
        @(negedge clock);
        check("div pulse", ctrl_div, 1);
        step(); step();
        md_ready = 1; md_exception = 1; fd_ir = bex;
        @(negedge clock);
        check("div exc wd", md_wd, 30);
        check("div exc data", md_data, 5);
        check("bex exc stall", stall, 1);
        step(); md_ready = 0; md_exception = 0; fd_ir = nop;
        step(); dx_ir = enc(0, 4, 1, 2, 6);
        step(); dx_ir = nop;
        step();
        md_ready = 1; md_exception = 1;
        @(negedge clock);
        check("mult exc wd", md_wd, 30);
        check("mult exc data", md_data, 4);
        step(); md_ready = 0; md_exception = 0;

        // Timeout: 40 busy cycles without a result.
        step(); dx_ir = enc(0, 5, 1, 2, 6);
        step(); dx_ir = nop;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clock);
            check("tmo busy", busy, 1);
            check("tmo no we", md_we, 0);
            step();
        end
        @(negedge clock);
        check("tmo idle", busy, 0);
        check("tmo set", md_timeout, 1);
        step(); step();
        @(negedge clock);
        check("tmo sticky", md_timeout, 1);

        // Reset while a buffered result waits.
        dx_ir = enc(0, 9, 1, 2, 6);
        step(); dx_ir = nop;
        step(); md_ready = 1; md_result = 11; mw_we = 1;
        step(); md_ready = 0; mw_we = 0; reset = 1;
        @(negedge clock);
        check("rst hold we", md_we, 0);
        step(); reset = 0;
        @(negedge clock);
        check("rst hold busy", busy, 0);
        check("rst hold pw", pw_ir, 0);
        check("rst hold we2", md_we, 0);
        check("rst clr tmo", md_timeout, 0);

        // r0 destination retires without a write.
        dx_ir = enc(0, 0, 1, 2, 6);
        step(); dx_ir = nop;
        step(); md_ready = 1; md_result = 99;
        @(negedge clock);
        check("r0 no we", md_we, 0);
        step(); md_ready = 0;
        @(negedge clock);
        check("r0 done", busy, 0);

        // Random traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            step();
            reset        = ($urandom_range(0, 249) == 0);
            fd_ir        = rand_ir();
            dx_ir        = ($urandom_range(0, 3) == 0)
                           ? enc(0, rreg(), rreg(), rreg(), $urandom_range(6, 7)) : rand_ir();
            mw_we        = ($urandom_range(0, 2) == 0);
            md_ready     = ($urandom_range(0, 9) == 0);
            md_exception = ($urandom_range(0, 3) == 0);
            md_result    = $urandom;
        end
        step();
        reset = 0; dx_ir = nop; fd_ir = nop; md_ready = 0; mw_we = 0;
        repeat (3) step();
        @(negedge clock);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
